// File: rtl/uart_tx_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl_pkg
//   Shared definitions for the UART transmit controller and the TX line mux
//   downstream of it.
//   - tx_state_e    : frame sequencer states
//   - SEL_* codes   : 4:1 line mux select values (shared with the mux)
//   - sel_of_state  : pure decode from sequencer state to mux select
// ---------------------------------------------------------------------------
package uart_tx_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Line mux select codes: 00 drives a constant 0 (start bit), 01 a
    // constant 1 (idle / stop), 10 the serial data bit, 11 the parity bit.
    localparam logic [1:0] SEL_START = 2'b00;
    localparam logic [1:0] SEL_IDLE  = 2'b01;
    localparam logic [1:0] SEL_DATA  = 2'b10;
    localparam logic [1:0] SEL_PAR   = 2'b11;

    function automatic logic [1:0] sel_of_state(input tx_state_e st);
        logic [1:0] sel;
        case (st)
            ST_START:  sel = SEL_START;
            ST_DATA:   sel = SEL_DATA;
            ST_PARITY: sel = SEL_PAR;
            default:   sel = SEL_IDLE;   // IDLE and STOP both hold the line high
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl_if
//   Byte-in / mux-control-out bundle of the UART transmit controller.
//   Handshake: the source presents P_DATA/PAR_EN/PAR_TYP with Data_Valid=1;
//   the byte is taken on the CLK edge where the controller is idle or in its
//   stop bit. Busy=1 means a Data_Valid outside those states is ignored.
//   Signals:
//     P_DATA     parallel data to send
//     Data_Valid P_DATA valid strobe
//     PAR_EN     1 = append parity bit
//     PAR_TYP    0 = even, 1 = odd parity
//     Ser_Data   current serial data bit (mux input 10)
//     Par_Bit    parity bit of the frame (mux input 11)
//     SEL        line mux select
//     Busy       frame in progress
//   Modports: master = byte source side, slave = transmit controller.
// ---------------------------------------------------------------------------
interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  Ser_Data;
    logic                  Par_Bit;
    logic [1:0]            SEL;
    logic                  Busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        input  Ser_Data, Par_Bit, SEL, Busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        output Ser_Data, Par_Bit, SEL, Busy
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
//   Shift register and bit counter for the data phase of a UART frame.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     load        capture load_data and clear the bit counter
//     shift_en    one data bit has been sent: shift right, advance counter
//     load_data   byte to serialize
//     ser_bit     current data bit (shift register LSB)
//     done        asserted during the last data bit of the frame
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  ser_bit,
    output logic                  done
);
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CW-1:0]         bit_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (load) begin
            shift_reg <= load_data;
            bit_cnt   <= '0;
        end else if (shift_en) begin
            // Zero fill: once a frame is out the register drains to 0.
            shift_reg <= {1'b0, shift_reg[DATA_WIDTH-1:1]};
            bit_cnt   <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
        end
    end

    assign ser_bit = shift_reg[0];
    assign done    = shift_en && (bit_cnt == LAST_BIT);

endmodule

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
//   UART transmit sequencer and datapath. Accepts a byte, then walks
//   START -> DATA x DATA_WIDTH -> [PARITY] -> STOP, one bit per CLK cycle,
//   driving the select and data inputs of the downstream 4:1 line mux.
//   A byte offered during the stop bit starts the next frame with no gap.
//   Ports:
//     CLK        baud-rate clock
//     RST        asynchronous active-low reset
//     bus        uart_tx_ctrl_if slave (byte in, mux controls out)
//     dbg_state  current sequencer state
// ---------------------------------------------------------------------------
module uart_tx_ctrl
    import uart_tx_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    uart_tx_ctrl_if.slave bus,
    output tx_state_e  dbg_state
);
    tx_state_e state;
    tx_state_e next_state;
    logic      busy_q;
    logic      par_en_q;
    logic      par_bit_q;
    logic      accept;
    logic      ser_bit;
    logic      ser_done;

    // A byte is taken only while the line is idle or sending the stop bit.
    assign accept = ((state == ST_IDLE) || (state == ST_STOP)) && bus.Data_Valid;

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .clk       (CLK),
        .rst_n     (RST),
        .load      (accept),
        .shift_en  (state == ST_DATA),
        .load_data (bus.P_DATA),
        .ser_bit   (ser_bit),
        .done      (ser_done)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (accept) next_state = ST_START;
            ST_START:  next_state = ST_DATA;
            ST_DATA:   if (ser_done) next_state = par_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY: next_state = ST_STOP;
            ST_STOP:   next_state = accept ? ST_START : ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // PAR_TYP only influences the parity bit value, so it is folded into
    // par_bit_q at accept time rather than kept as separate state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= ST_IDLE;
            busy_q    <= 1'b0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            state  <= next_state;
            busy_q <= (next_state != ST_IDLE);
            if (accept) begin
                par_en_q  <= bus.PAR_EN;
                par_bit_q <= (^bus.P_DATA) ^ bus.PAR_TYP;
            end
        end
    end

    assign bus.SEL      = sel_of_state(state);
    assign bus.Busy     = busy_q;
    assign bus.Par_Bit  = par_bit_q;
    assign bus.Ser_Data = ser_bit;
    assign dbg_state    = state;

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Transmit-side control and datapath for the UART TX, directly upstream of the TX output 4:1 line mux. The block accepts a parallel byte with a valid strobe, sequences start/data/parity/stop, serializes the data LSB first and computes the parity bit. It drives the mux select code plus the Ser_Data and Par_Bit mux inputs; the mux output is the TX line.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (range 5..9).

Ports:
CLK  input  1  TX clock; one frame bit per CLK cycle (baud-rate clock).
RST  input  1  asynchronous active-low reset.
P_DATA  input  DATA_WIDTH  parallel data to send.
Data_Valid  input  1  P_DATA valid strobe; sampled only when the block may accept.
PAR_EN  input  1  1 = insert parity bit.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
Ser_Data  output  1  current serial data bit, to mux input 2'b10.
Par_Bit  output  1  computed parity bit, to mux input 2'b11.
SEL  output  2  mux select: 00 start (line 0), 01 idle/stop (line 1), 10 data, 11 parity.
Busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (RST low, async): state IDLE, SEL=01, Busy=0, Ser_Data=0, Par_Bit=0, bit counter=0, shift register=0. A reset mid-frame aborts immediately; the line returns high with no partial stop bit.
- FSM states: IDLE, START, DATA, PARITY, STOP. SEL is a pure decode of the registered state: IDLE/STOP→01, START→00, DATA→10, PARITY→11.
- Accept condition: state IDLE, or state STOP, with Data_Valid=1 at the CLK edge. On accept:
  - Latch P_DATA into the shift register; latch PAR_EN and PAR_TYP.
  - Compute and register Par_Bit = ^P_DATA XOR PAR_TYP.
  - Next state START.
- Data_Valid in START/DATA/PARITY is ignored and has no effect on the frame or on the latched settings.
- START lasts 1 cycle, then DATA.
- DATA lasts exactly DATA_WIDTH cycles.
  - Ser_Data = shift_reg[0]; the register shifts right once per DATA cycle, so bits go out LSB first.
  - The bit counter runs 0..DATA_WIDTH-1 and wraps to 0 on the last bit.
- After the last data bit: next state PARITY if latched PAR_EN=1, else STOP.
- PARITY lasts 1 cycle, then STOP.
- STOP lasts 1 cycle.
  - Next state START if Data_Valid=1 (back-to-back frame, no idle gap), else IDLE.
- Busy is registered.
  - Rises on the edge that enters START and stays 1 through STOP.
  - Falls on the edge entering IDLE.
  - Stays 1 on a STOP→START transition.
- Frame length: 2 + DATA_WIDTH + PAR_EN cycles.
- Latency: SEL becomes 00 on the first edge after Data_Valid is sampled.
- Par_Bit holds its value until the next accept.
- Inputs P_DATA, PAR_EN and PAR_TYP may change freely after accept without affecting the current frame.

Decomposition:
- Shared package: state encoding (IDLE..STOP) and the SEL code constants SEL_START=00, SEL_IDLE=01, SEL_DATA=10, SEL_PAR=11. The mux and this block use the same constants.
- One natural sub-module: uart_tx_serializer. It holds the shift register, the bit counter and a done flag, with load/shift-enable inputs from the FSM.
- Parity is a single reduction XOR in the top.

Test Plan:
- Reset: assert RST low mid-DATA of a frame → SEL=01, Busy=0 immediately with no clock; after release, the next Data_Valid starts a clean frame.
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, one Data_Valid pulse → SEL sequence 00, 10×8, 11, 01. Ser_Data during DATA = 1,0,1,0,0,1,0,1. Par_Bit=0. Busy high for 11 cycles.
- Same data with PAR_TYP=1 → Par_Bit=1. With PAR_EN=0 → no 11 cycle, frame is 10 cycles, STOP follows the 8th data bit.
- Back-to-back: Data_Valid=1 with P_DATA=0x3C during the STOP cycle of a 0xA5 frame → next cycle SEL=00, Busy never drops, second frame serializes 0,0,1,1,1,1,0,0.
- Data_Valid pulsed with P_DATA=0xFF during DATA of a 0x00 frame → all eight data bits remain 0, no extra frame, Busy falls after STOP.
- P_DATA changed to 0x00 one cycle after accepting 0xA5 → transmitted bits and Par_Bit still match 0xA5.
